// File: rtl/core_imem_pkg.sv
// Shared types and constants for the rotation-core pixel buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package core_imem_pkg;

  // Drain-side state of the buffer: waiting for a complete set, or replaying one.
  typedef enum logic [1:0] {
    P_FILL  = 2'h0,
    P_DRAIN = 2'h1
  } imem_state_e;

  // Rotation amounts, same encoding as core_set.
  localparam logic [1:0] P_DEG_0   = 2'd0;
  localparam logic [1:0] P_DEG_90  = 2'd1;
  localparam logic [1:0] P_DEG_180 = 2'd2;
  localparam logic [1:0] P_DEG_270 = 2'd3;

  localparam int P_SET_PIX = 64;

  // Clockwise rotation equivalent to the requested degrees/direction pair.
  function automatic logic [1:0] eff_rot(input logic [1:0] degrees, input logic direction);
    return direction ? degrees : (2'd0 - degrees);
  endfunction

endpackage

// File: rtl/core_imem_rotidx.sv
// Maps a raster output index to the source index of a clockwise-rotated square set.
// Latency: combinational.
// Backpressure: none (pure function).
module core_imem_rotidx
  import core_imem_pkg::*;
#(
  parameter int P_DIM_W = 3
) (
  input  logic [1:0]           eff_i,
  input  logic [2*P_DIM_W-1:0] o_i,
  output logic [2*P_DIM_W-1:0] src_o
);

  logic [P_DIM_W-1:0] row;
  logic [P_DIM_W-1:0] col;

  assign row = o_i[2*P_DIM_W-1:P_DIM_W];
  assign col = o_i[P_DIM_W-1:0];

  // Edge length is a power of two, so (DIM-1)-x is simply ~x.
  always_comb begin
    src_o = o_i;
    case (eff_i)
      P_DEG_0:   src_o = {row, col};
      P_DEG_90:  src_o = {~col, row};
      P_DEG_180: src_o = {~row, ~col};
      P_DEG_270: src_o = {col, ~row};
      default:   src_o = o_i;
    endcase
  end

endmodule

// File: rtl/core_imem.sv
// Pixel set buffer: captures one raster set, replays it rotated; IMEM_PINGPONG_EN adds a second bank.
// Latency: first rotated pixel valid the cycle after the last write accept; 1 pixel/cycle each side.
// Backpressure: WREADY low while the fill bank awaits drain; RDATA held while RVALID && !RREADY.
module core_imem
  import core_imem_pkg::*;
#(
  parameter int P_PIX_W   = 24,
  parameter int P_SET_DIM = 8
) (
  input  logic               I_IM_HCLK,
  input  logic               I_IM_HRESET_N,
  input  logic               I_IM_CLEAR,
  input  logic [P_PIX_W-1:0] I_IM_WDATA,
  input  logic               I_IM_WVALID,
  output logic               O_IM_WREADY,
  input  logic               I_IM_PAD,
  input  logic [1:0]         I_IM_DEGREES,
  input  logic               I_IM_DIRECTION,
  output logic [P_PIX_W-1:0] O_IM_RDATA,
  output logic               O_IM_RVALID,
  input  logic               I_IM_RREADY,
  output logic [15:0]        O_IM_SETS
);

  localparam int DIM_W   = $clog2(P_SET_DIM);
  localparam int IDX_W   = 2 * DIM_W;
  localparam int SET_PIX = P_SET_DIM * P_SET_DIM;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  imem_state_e        state_q, state_d;
  logic [IDX_W-1:0]   w_idx_q, w_idx_d;
  logic [IDX_W-1:0]   o_q, o_d;
  logic [IDX_W-1:0]   load_o, src_addr;
  logic [P_PIX_W-1:0] rdata_q, rdata_d;
  logic [P_PIX_W-1:0] wr_val, rd_val;
  logic [15:0]        sets_q, sets_d;
  logic [1:0]         eff_in, rd_eff;
  logic               wready, rvalid;
  logic               wr_acc, rd_acc, fill_done, drain_done;
  logic               next_rdy, load, fwd;

  assign rvalid     = (state_q == P_DRAIN);
  assign wr_acc     = I_IM_WVALID & wready;
  assign rd_acc     = rvalid & I_IM_RREADY;
  assign fill_done  = wr_acc & (w_idx_q == LAST_IDX);
  assign drain_done = rd_acc & (o_q == LAST_IDX);
  assign wr_val     = I_IM_PAD ? '0 : I_IM_WDATA;
  assign eff_in     = eff_rot(I_IM_DEGREES, I_IM_DIRECTION);

  core_imem_rotidx #(.P_DIM_W(DIM_W)) u_rotidx (
    .eff_i (rd_eff),
    .o_i   (load_o),
    .src_o (src_addr)
  );

`ifdef IMEM_PINGPONG_EN
  logic                 fb_q, fb_d, db_q, db_d, rd_bank;
  logic [1:0]           full_q, full_d;
  logic [1:0][1:0]      eff_q, eff_d;
  logic [P_PIX_W-1:0]   mem_q [2*SET_PIX];

  assign wready   = ~full_q[fb_q];
  // While draining, a fill can only complete into the other bank, so it counts as "next ready".
  assign next_rdy = full_q[~db_q] | fill_done;
  assign rd_bank  = (state_q == P_FILL) ? fb_q : (drain_done ? ~db_q : db_q);
  assign rd_eff   = (fill_done && (rd_bank == fb_q)) ? eff_in : eff_q[rd_bank];
  // The pixel written on this edge may be the very one the output register wants.
  assign fwd      = wr_acc && (rd_bank == fb_q) && (src_addr == w_idx_q);
  assign rd_val   = fwd ? wr_val : mem_q[{rd_bank, src_addr}];

  // Bank bookkeeping: fill/drain pointers, occupancy and per-bank rotation.
  always_comb begin
    fb_d   = fb_q;
    db_d   = db_q;
    full_d = full_q;
    eff_d  = eff_q;
    if (fill_done) begin
      full_d[fb_q] = 1'b1;
      eff_d[fb_q]  = eff_in;
      fb_d         = ~fb_q;
      if (state_q == P_FILL) db_d = fb_q;
    end
    if (drain_done) begin
      full_d[db_q] = 1'b0;
      db_d         = ~db_q;
    end
    if (I_IM_CLEAR) begin
      fb_d   = 1'b0;
      db_d   = 1'b0;
      full_d = '0;
    end
  end

  // Bank bookkeeping registers.
  always_ff @(posedge I_IM_HCLK or negedge I_IM_HRESET_N) begin
    if (!I_IM_HRESET_N) begin
      fb_q   <= 1'b0;
      db_q   <= 1'b0;
      full_q <= '0;
      eff_q  <= '0;
    end else begin
      fb_q   <= fb_d;
      db_q   <= db_d;
      full_q <= full_d;
      eff_q  <= eff_d;
    end
  end

  // Pixel storage; contents survive clear and reset.
  always_ff @(posedge I_IM_HCLK) begin
    if (wr_acc && !I_IM_CLEAR) mem_q[{fb_q, w_idx_q}] <= wr_val;
  end
`else
  logic [1:0]           eff_q, eff_d;
  logic [P_PIX_W-1:0]   mem_q [SET_PIX];

  assign wready   = (state_q == P_FILL);
  assign next_rdy = 1'b0;
  assign rd_eff   = (state_q == P_FILL) ? eff_in : eff_q;
  // The pixel written on this edge may be the very one the output register wants.
  assign fwd      = wr_acc && (src_addr == w_idx_q);
  assign rd_val   = fwd ? wr_val : mem_q[src_addr];

  // Rotation is frozen when the set completes so mid-drain input changes are ignored.
  always_comb begin
    eff_d = eff_q;
    if (fill_done) eff_d = eff_in;
  end

  // Rotation register.
  always_ff @(posedge I_IM_HCLK or negedge I_IM_HRESET_N) begin
    if (!I_IM_HRESET_N) eff_q <= P_DEG_0;
    else                eff_q <= eff_d;
  end

  // Pixel storage; contents survive clear and reset.
  always_ff @(posedge I_IM_HCLK) begin
    if (wr_acc && !I_IM_CLEAR) mem_q[w_idx_q] <= wr_val;
  end
`endif

  // Fill/drain sequencing; clear overrides every accept in the same cycle.
  always_comb begin
    state_d = state_q;
    w_idx_d = w_idx_q;
    o_d     = o_q;
    sets_d  = sets_q;
    load    = 1'b0;
    load_o  = '0;
    if (wr_acc) w_idx_d = fill_done ? '0 : (w_idx_q + IDX_W'(1));
    case (state_q)
      P_FILL: begin
        if (fill_done) begin
          state_d = P_DRAIN;
          load    = 1'b1;
        end
      end
      P_DRAIN: begin
        if (rd_acc) begin
          if (drain_done) begin
            o_d    = '0;
            sets_d = sets_q + 16'd1;
            if (next_rdy) load = 1'b1;
            else          state_d = P_FILL;
          end else begin
            o_d    = o_q + IDX_W'(1);
            load_o = o_q + IDX_W'(1);
            load   = 1'b1;
          end
        end
      end
      default: state_d = P_FILL;
    endcase
    if (I_IM_CLEAR) begin
      state_d = P_FILL;
      w_idx_d = '0;
      o_d     = '0;
      sets_d  = sets_q;
      load    = 1'b0;
    end
  end

  // Output register only moves on a new pixel, so it holds through stalls.
  always_comb begin
    rdata_d = rdata_q;
    if (load) rdata_d = rd_val;
  end

  // Control and output registers.
  always_ff @(posedge I_IM_HCLK or negedge I_IM_HRESET_N) begin
    if (!I_IM_HRESET_N) begin
      state_q <= P_FILL;
      w_idx_q <= '0;
      o_q     <= '0;
      rdata_q <= '0;
      sets_q  <= '0;
    end else begin
      state_q <= state_d;
      w_idx_q <= w_idx_d;
      o_q     <= o_d;
      rdata_q <= rdata_d;
      sets_q  <= sets_d;
    end
  end

  assign O_IM_WREADY = wready;
  assign O_IM_RVALID = rvalid;
  assign O_IM_RDATA  = rdata_q;
  assign O_IM_SETS   = sets_q;

endmodule

// File: tb/tb_core_imem.sv
// Directed bench for core_imem: rotations, padding, stalls, clear, reset, optional pingpong.
// Latency: checks first pixel one cycle after the last write accept.
// Backpressure: drives RREADY steady or toggling and checks RDATA holds on stalls.
module tb_core_imem;

  logic        clk, rst_n, clear, wvalid, wready, pad, dir, rvalid, rready;
  logic [23:0] wdata, rdata;
  logic [1:0]  deg;
  logic [15:0] sets;
  int          n_checks = 0;
  int          n_err = 0;
  logic [23:0] out_q [64];

`ifdef IMEM_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  core_imem dut (
    .I_IM_HCLK      (clk),
    .I_IM_HRESET_N  (rst_n),
    .I_IM_CLEAR     (clear),
    .I_IM_WDATA     (wdata),
    .I_IM_WVALID    (wvalid),
    .O_IM_WREADY    (wready),
    .I_IM_PAD       (pad),
    .I_IM_DEGREES   (deg),
    .I_IM_DIRECTION (dir),
    .O_IM_RDATA     (rdata),
    .O_IM_RVALID    (rvalid),
    .I_IM_RREADY    (rready),
    .O_IM_SETS      (sets)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus patterns: 0 = 17*k, 1 = k, 2 = 0x100+k with columns 5..7 padded, 3 = junk.
  function automatic logic [23:0] pix_raw(input int pat, input int k);
    case (pat)
      0:       return 24'(17 * k);
      1:       return 24'(k);
      2:       return 24'(256 + k);
      default: return 24'(24'hABC000 + k);
    endcase
  endfunction

  function automatic logic padded(input int pat, input int k);
    return (pat == 2) && ((k % 8) >= 5);
  endfunction

  // Expected output pixel o for clockwise rotation eff.
  function automatic logic [23:0] exp_pix(input int pat, input int eff, input int o);
    int i, j, r, c;
    i = o / 8;
    j = o % 8;
    case (eff)
      0:       begin r = i;     c = j;     end
      1:       begin r = 7 - j; c = i;     end
      2:       begin r = 7 - i; c = 7 - j; end
      default: begin r = j;     c = 7 - i; end
    endcase
    return padded(pat, r * 8 + c) ? 24'h0 : pix_raw(pat, r * 8 + c);
  endfunction

  task automatic push(input int pat, input logic [1:0] degv, input logic dirv, input int n, input logic exp_rv);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("push_wready", 32'(wready), 32'd1);
      chk("push_rvalid", 32'(rvalid), 32'(exp_rv));
      wvalid = 1'b1;
      wdata  = pix_raw(pat, k);
      pad    = padded(pat, k);
      deg    = degv;
      dir    = dirv;
    end
  endtask

  task automatic end_fill();
    @(negedge clk);
    wvalid = 1'b0;
    pad    = 1'b0;
    chk("fill_rvalid", 32'(rvalid), 32'd1);
    chk("fill_wready", 32'(wready), 32'(PP));
  endtask

  task automatic pull(input int pat, input int eff, input logic toggle, input int n);
    int          got, cyc;
    logic        stalled;
    logic [23:0] held;
    got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < n && cyc < 1000) begin
      chk("drain_rvalid", 32'(rvalid), 32'd1);
      if (stalled) chk("stall_hold", 32'(rdata), 32'(held));
      chk("drain_rdata", 32'(rdata), 32'(exp_pix(pat, eff, got)));
      out_q[got] = rdata;
      rready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (rready) begin
        got++;
        stalled = 1'b0;
      end else begin
        held    = rdata;
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    chk("drain_count", 32'(got), 32'(n));
  endtask

  task automatic post_drain(input int exp_sets);
    chk("sets", 32'(sets), 32'(exp_sets));
    chk("idle_rvalid", 32'(rvalid), 32'd0);
    chk("idle_wready", 32'(wready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; wvalid = 1'b0; wdata = '0; pad = 1'b0;
    deg = 2'd0; dir = 1'b1; rready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_sets", 32'(sets), 32'd0);
    rst_n = 1'b1;

    // Identity
    push(0, 2'd0, 1'b1, 64, 1'b0);
    end_fill();
    pull(0, 0, 1'b0, 64);
    post_drain(1);
    chk("id_o5", 32'(out_q[5]), 32'h55);
    chk("id_o63", 32'(out_q[63]), 32'h42F);

    // CW 90; inputs changed mid-drain must be ignored
    push(1, 2'd1, 1'b1, 64, 1'b0);
    end_fill();
    deg = 2'd0; dir = 1'b0;
    pull(1, 1, 1'b0, 64);
    post_drain(2);
    chk("cw90_o0", 32'(out_q[0]), 32'd56);
    chk("cw90_o1", 32'(out_q[1]), 32'd48);
    chk("cw90_o7", 32'(out_q[7]), 32'd0);
    chk("cw90_o8", 32'(out_q[8]), 32'd57);
    chk("cw90_o63", 32'(out_q[63]), 32'd7);

    // CCW 90 == CW 270
    push(1, 2'd1, 1'b0, 64, 1'b0);
    end_fill();
    pull(1, 3, 1'b0, 64);
    post_drain(3);
    chk("ccw90_o0", 32'(out_q[0]), 32'd7);
    chk("ccw90_o1", 32'(out_q[1]), 32'd15);
    chk("ccw90_o7", 32'(out_q[7]), 32'd63);
    chk("ccw90_o8", 32'(out_q[8]), 32'd6);

    // 180 via CCW; first source pixel is the last one written
    push(1, 2'd2, 1'b0, 64, 1'b0);
    end_fill();
    pull(1, 2, 1'b0, 64);
    post_drain(4);
    chk("r180_o0", 32'(out_q[0]), 32'd63);
    chk("r180_o9", 32'(out_q[9]), 32'd54);
    chk("r180_o63", 32'(out_q[63]), 32'd0);

    // CW 270 with padding on columns 5..7 and toggling RREADY
    push(2, 2'd3, 1'b1, 64, 1'b0);
    end_fill();
    pull(2, 3, 1'b1, 64);
    post_drain(5);
    chk("pad_o0", 32'(out_q[0]), 32'd0);
    chk("pad_o5", 32'(out_q[5]), 32'd0);
    chk("pad_o40", 32'(out_q[40]), 32'h102);
    chk("pad_o47", 32'(out_q[47]), 32'h13A);
    chk("pad_o63", 32'(out_q[63]), 32'h138);

    // Clear after 30 writes, with a write offered in the clear cycle
    push(3, 2'd0, 1'b1, 30, 1'b0);
    @(negedge clk);
    clear = 1'b1; wvalid = 1'b1; wdata = 24'hDEAD00;
    @(negedge clk);
    clear = 1'b0; wvalid = 1'b0;
    chk("clr_wready", 32'(wready), 32'd1);
    chk("clr_rvalid", 32'(rvalid), 32'd0);
    push(1, 2'd0, 1'b1, 64, 1'b0);
    end_fill();
    pull(1, 0, 1'b0, 64);
    post_drain(6);
    chk("clr_o29", 32'(out_q[29]), 32'd29);
    chk("clr_o30", 32'(out_q[30]), 32'd30);

`ifdef IMEM_PINGPONG_EN
    // Second set fills while the first is stalled; both then drain back-to-back
    push(1, 2'd0, 1'b1, 64, 1'b0);
    end_fill();
    push(0, 2'd2, 1'b0, 64, 1'b1);
    @(negedge clk);
    wvalid = 1'b0;
    chk("pp_wready_full", 32'(wready), 32'd0);
    chk("pp_rvalid", 32'(rvalid), 32'd1);
    pull(1, 0, 1'b0, 64);
    pull(0, 2, 1'b0, 64);
    post_drain(8);
`endif

    // Reset at drain pixel 20
    push(0, 2'd0, 1'b1, 64, 1'b0);
    end_fill();
    pull(0, 0, 1'b0, 20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_sets", 32'(sets), 32'd0);
    chk("mid_rst_wready", 32'(wready), 32'd1);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1, 2'd2, 1'b1, 64, 1'b0);
    end_fill();
    pull(1, 2, 1'b0, 64);
    post_drain(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
